// File: rtl/key_scan_ctrl.sv
// ============================================================================
// Module   : key_scan_ctrl
// Brief    : 4-key debouncer with one shared debounce counter, round-robin
//            arbitration and an event queue.
//            Define KEY_EVTFIFO_EN for a 4-entry event FIFO; otherwise a
//            single holding register is used.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_scan_ctrl #(
    parameter logic [18:0] T10MS = 19'd500_000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic       EvtValid,
    input  logic       EvtReady,
    output logic [2:0] EvtCode,
    output logic [3:0] KeyState,
    output logic       Overflow
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_CONFIRM  = 2'd2;

    logic [3:0]  r_f1;
    logic [3:0]  r_f2;
    logic [3:0]  r_keystate;
    logic [1:0]  r_state;
    logic [18:0] r_c1;
    logic [1:0]  r_g;
    logic [1:0]  r_rr;
    logic        r_ovf;

    logic [3:0]  w_mismatch;
    logic        w_found;
    logic [1:0]  w_gidx;
    logic [1:0]  w_cand;
    logic [1:0]  w_state_nxt;
    logic [18:0] w_c1_nxt;
    logic [1:0]  w_g_nxt;
    logic [1:0]  w_rr_nxt;
    logic [3:0]  w_ks_nxt;
    logic        w_enq;
    logic [2:0]  w_enq_code;
    logic        w_deq;
    logic        w_full;
    logic        w_push;

    assign w_mismatch = r_f2 ^ r_keystate;

    // Round-robin search starting one past the last key that produced an event
    always_comb begin
        w_found = 1'b0;
        w_gidx  = r_rr;
        w_cand  = r_rr;
        for (int i = 1; i <= 4; i++) begin
            w_cand = r_rr + 2'(i);
            if (!w_found && w_mismatch[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c1_nxt    = r_c1;
        w_g_nxt     = r_g;
        w_rr_nxt    = r_rr;
        w_ks_nxt    = r_keystate;
        w_enq       = 1'b0;
        w_enq_code  = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_g_nxt     = w_gidx;
                    w_c1_nxt    = 19'd0;
                    w_state_nxt = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (r_c1 == T10MS - 19'd1) begin
                    w_c1_nxt    = 19'd0;
                    w_state_nxt = S_CONFIRM;
                end else begin
                    w_c1_nxt = r_c1 + 19'd1;
                end
            end
            S_CONFIRM: begin
                // Only this sample decides; a key that bounced back yields nothing
                if (r_f2[r_g] != r_keystate[r_g]) begin
                    w_ks_nxt[r_g] = r_f2[r_g];
                    w_enq         = 1'b1;
                    w_enq_code    = {~r_f2[r_g], r_g};
                    w_rr_nxt      = r_g;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_f1       <= 4'b1111;
            r_f2       <= 4'b1111;
            r_keystate <= 4'b1111;
            r_state    <= S_IDLE;
            r_c1       <= 19'd0;
            r_g        <= 2'd0;
            r_rr       <= 2'd3;
        end else begin
            r_f1       <= KEY;
            r_f2       <= r_f1;
            r_keystate <= w_ks_nxt;
            r_state    <= w_state_nxt;
            r_c1       <= w_c1_nxt;
            r_g        <= w_g_nxt;
            r_rr       <= w_rr_nxt;
        end
    end

    assign w_deq  = EvtValid && EvtReady;
    assign w_push = w_enq && (!w_full || w_deq);

`ifdef KEY_EVTFIFO_EN
    logic [2:0] r_mem [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_cnt;

    assign w_full   = (r_cnt == 3'd4);
    assign EvtValid = (r_cnt != 3'd0);
    assign EvtCode  = r_mem[r_rp];

    // On full with a dequeue, the write lands in the slot being vacated
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 3'b000;
            end
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_enq_code;
                r_wp        <= r_wp + 2'd1;
            end
            if (w_deq) begin
                r_rp <= r_rp + 2'd1;
            end
            r_cnt <= r_cnt + 3'(w_push) - 3'(w_deq);
        end
    end
`else
    logic       r_hold_v;
    logic [2:0] r_hold;

    assign w_full   = r_hold_v;
    assign EvtValid = r_hold_v;
    assign EvtCode  = r_hold;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_hold_v <= 1'b0;
            r_hold   <= 3'b000;
        end else if (w_push) begin
            r_hold_v <= 1'b1;
            r_hold   <= w_enq_code;
        end else if (w_deq) begin
            r_hold_v <= 1'b0;
        end
    end
`endif

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_ovf <= 1'b0;
        end else if (w_enq && w_full && !w_deq) begin
            r_ovf <= 1'b1;
        end
    end

    assign KeyState = r_keystate;
    assign Overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_key_scan_ctrl.sv
// ============================================================================
// Module   : tb_key_scan_ctrl
// Brief    : Self-checking bench for key_scan_ctrl (T10MS = 10) against a
//            queue-based behavioural model; honours KEY_EVTFIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_scan_ctrl;

    localparam int T = 10;
`ifdef KEY_EVTFIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] KEY = 4'b1111;
    logic       EvtValid;
    logic       EvtReady = 1'b0;
    logic [2:0] EvtCode;
    logic [3:0] KeyState;
    logic       Overflow;

    key_scan_ctrl #(.T10MS(19'(T))) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .KEY      (KEY),
        .EvtValid (EvtValid),
        .EvtReady (EvtReady),
        .EvtCode  (EvtCode),
        .KeyState (KeyState),
        .Overflow (Overflow)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    // Model: sync pipe, debounced levels, owner key with edges left until its verdict
    logic [3:0] m_s1, m_s2, m_ks;
    int         m_rr, m_owner, m_rem;
    logic [2:0] m_q[$];
    logic       m_ovf;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic       enq;
        logic [2:0] code;
        bit         deq;
        bit         full;
        int         k;
        if (!RESET) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_ks = 4'hF;
            m_rr = 3; m_owner = -1; m_rem = 0;
            m_q.delete(); m_ovf = 1'b0;
            return;
        end
        enq  = 1'b0;
        code = 3'b000;
        if (m_owner < 0) begin
            for (int i = 1; i <= 4; i++) begin
                k = (m_rr + i) % 4;
                if (m_s2[k] != m_ks[k]) begin
                    m_owner = k;
                    m_rem   = T + 1;
                    break;
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_s2[m_owner] != m_ks[m_owner]) begin
                    m_ks[m_owner] = m_s2[m_owner];
                    enq  = 1'b1;
                    code = {~m_s2[m_owner], 2'(m_owner)};
                    m_rr = m_owner;
                end
                m_owner = -1;
            end
        end
        full = (m_q.size() == DEPTH);
        deq  = (m_q.size() > 0) && EvtReady;
        if (deq) void'(m_q.pop_front());
        if (enq) begin
            if (full && !deq) m_ovf = 1'b1;
            else m_q.push_back(code);
        end
        m_s2 = m_s1;
        m_s1 = KEY;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_step();
        #1;
        check("valid", int'(EvtValid), int'(m_q.size() > 0));
        check("keystate", int'(KeyState), int'(m_ks));
        check("overflow", int'(Overflow), int'(m_ovf));
        if (m_q.size() > 0) check("code", int'(EvtCode), int'(m_q[0]));
    endtask

    task automatic do_reset();
        KEY = 4'hF;
        EvtReady = 1'b0;
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!EvtValid && n < maxc) begin
            tick();
            n++;
        end
    endtask

    typedef struct packed {
        logic [3:0] key;
        logic [3:0] exp_ks;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[6];
    int   n;
    int   cyc;
    int   ev_cyc[$];
    int   ev_code[$];
    bit   seen;

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", int'(EvtValid), 0);
        check("rst_code", int'(EvtCode), 0);
        check("rst_keystate", int'(KeyState), 15);
        check("rst_overflow", int'(Overflow), 0);

        // Single press: latency and one-cycle pulse
        EvtReady = 1'b1;
        KEY = 4'b1011;
        wait_valid(40, n);
        check("press_latency", n, 14);
        check("press_code", int'(EvtCode), 6);
        check("press_keystate", int'(KeyState), 4'hB);
        tick();
        check("press_pulse", int'(EvtValid), 0);
        KEY = 4'hF;
        wait_valid(40, n);
        check("release_code", int'(EvtCode), 2);
        repeat (4) tick();

        // Glitch shorter than the window
        do_reset();
        EvtReady = 1'b1;
        KEY = 4'b1101;
        repeat (3) tick();
        KEY = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= EvtValid;
        end
        check("glitch_event", int'(seen), 0);
        check("glitch_keystate", int'(KeyState), 15);

        // All keys at once: round-robin order, 12 cycles apart
        do_reset();
        EvtReady = 1'b1;
        KEY = 4'h0;
        ev_cyc.delete();
        ev_code.delete();
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (EvtValid) begin
                ev_cyc.push_back(i);
                ev_code.push_back(int'(EvtCode));
            end
        end
        check("rr_count", ev_cyc.size(), 4);
        for (int i = 0; i < 4 && i < ev_cyc.size(); i++) begin
            check("rr_code", ev_code[i], 4 + i);
            check("rr_time", ev_cyc[i], 14 + 12 * i);
        end

        // Stalled consumer, six key edges, then drain
        tbl[0] = '{key: 4'b1110, exp_ks: 4'b1110, exp_ovf: 1'b0};
        tbl[1] = '{key: 4'b1100, exp_ks: 4'b1100, exp_ovf: 1'b0};
        tbl[2] = '{key: 4'b1000, exp_ks: 4'b1000, exp_ovf: 1'b0};
        tbl[3] = '{key: 4'b0000, exp_ks: 4'b0000, exp_ovf: 1'b0};
        tbl[4] = '{key: 4'b0001, exp_ks: 4'b0001, exp_ovf: 1'b0};
        tbl[5] = '{key: 4'b0011, exp_ks: 4'b0011, exp_ovf: 1'b0};
        for (int i = 0; i < 6; i++) tbl[i].exp_ovf = (i + 1 > DEPTH);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            KEY = tbl[i].key;
            repeat (16) tick();
            check("stall_keystate", int'(KeyState), int'(tbl[i].exp_ks));
            check("stall_overflow", int'(Overflow), int'(tbl[i].exp_ovf));
        end
        EvtReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", int'(EvtValid), 1);
            check("drain_code", int'(EvtCode), 4 + i);
            tick();
        end
        check("drain_empty", int'(EvtValid), 0);

        // Reset in the middle of a debounce window
        do_reset();
        EvtReady = 1'b1;
        KEY = 4'b1110;
        repeat (8) tick();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        wait_valid(40, n);
        check("midrst_latency", n, 14);
        check("midrst_code", int'(EvtCode), 4);

        // Full queue with a dequeue on the enqueue edge
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            KEY[i] = 1'b0;
            repeat (16) tick();
        end
        KEY[0] = 1'b1;
        n = 0;
        while (!(m_owner == 0 && m_rem == 1) && n < 40) begin
            tick();
            n++;
        end
        check("full_reach", int'(n < 40), 1);
        EvtReady = 1'b1;
        tick();
        EvtReady = 1'b0;
        check("full_overflow", int'(Overflow), 0);
        check("full_valid", int'(EvtValid), 1);
        EvtReady = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            check("full_order", int'(EvtCode), (j == DEPTH - 1) ? 0 : 4 + j + 1);
            tick();
        end
        check("full_empty", int'(EvtValid), 0);

        // Randomised bouncing keys with a random consumer
        do_reset();
        for (cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0) KEY[$urandom_range(0, 3)] ^= 1'b1;
            EvtReady = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_scan_ctrl.md
KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 The module SHALL have parameter T10MS, default 19'd500_000, giving the debounce window in CLOCK cycles (2 <= T10MS < 2^19).
REQ-002 The module SHALL have port CLOCK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port RESET, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port KEY, input, 4 bits: raw asynchronous key pins, active-low (idle = 1).
REQ-005 The module SHALL have port EvtValid, output, 1 bit: the head event is available.
REQ-006 The module SHALL have port EvtReady, input, 1 bit: the consumer accepts the head event.
REQ-007 The module SHALL have port EvtCode, output, 3 bits: {type, index[1:0]}; type 1 = press, type 0 = release.
REQ-008 The module SHALL have port KeyState, output, 4 bits: the debounced level of each key.
REQ-009 The module SHALL have port Overflow, output, 1 bit: a sticky flag meaning an event was dropped.

Function
REQ-010 Each KEY bit SHALL pass through a 2-flop synchronizer F1->F2; SK[k] denotes the F2 output.
REQ-011 A single shared 19-bit debounce counter C1 SHALL serve all four keys; the FSM arbitrates access to it.
REQ-012 A key k SHALL be mismatched when SK[k] != KeyState[k].
REQ-013 The FSM SHALL have the states IDLE, DEBOUNCE and CONFIRM.
REQ-014 In IDLE, if any key is mismatched, the FSM SHALL grant the first mismatched key searched from (RR+1) mod 4 upward, latch its index into G, clear C1, and go to DEBOUNCE.
REQ-015 In IDLE with no mismatch, the FSM SHALL stay in IDLE.
REQ-016 In DEBOUNCE, C1 SHALL increment each cycle; when C1 == T10MS-1, C1 SHALL be cleared and the FSM SHALL go to CONFIRM, so DEBOUNCE lasts exactly T10MS cycles.
REQ-017 In CONFIRM, if SK[G] != KeyState[G], the block SHALL set KeyState[G] <= SK[G], enqueue event {~SK[G], G}, and set RR <= G.
REQ-018 In CONFIRM, if SK[G] == KeyState[G] (bounce), the block SHALL generate no event and leave RR unchanged.
REQ-019 CONFIRM SHALL always return to IDLE after one cycle.
REQ-020 Other keys SHALL NOT be granted while the FSM is in DEBOUNCE or CONFIRM; their mismatches SHALL wait, with none lost while the mismatch persists.
REQ-021 The level of the granted key during DEBOUNCE SHALL be ignored; only the sample in CONFIRM decides.
REQ-022 Latency with an empty queue SHALL be: a KEY change before edge e0 gives EvtValid = 1 after edge e0+T10MS+3 (T10MS+4 edges in total).
REQ-023 An event SHALL be dequeued on a rising edge where EvtValid && EvtReady.
REQ-024 EvtCode SHALL hold stable while EvtValid = 1 and EvtReady = 0.
REQ-025 An enqueue while the queue is full and no dequeue occurs in the same cycle SHALL drop the new event and set Overflow.
REQ-026 KeyState SHALL still update on a dropped event.
REQ-027 A simultaneous enqueue and dequeue on a full queue SHALL succeed with no drop.
REQ-028 A simultaneous enqueue and dequeue on an empty queue SHALL leave EvtValid = 1 with the new event.
REQ-029 Overflow SHALL clear only on reset.
REQ-030 When several keys change at once, events SHALL be emitted one per debounce window in round-robin order; starvation of any key SHALL be impossible.

Reset
REQ-031 When RESET = 0 at a rising edge, the following SHALL be reset: F1, F2 = 4'b1111; KeyState = 4'b1111; FSM = IDLE; C1 = 0; G = 0; RR = 3 (key 0 searched first); queue emptied; EvtValid = 0; EvtCode = 3'b000; Overflow = 0.
REQ-032 Reset mid-DEBOUNCE or mid-CONFIRM SHALL abandon the grant with no event.
REQ-033 A key held low through reset SHALL produce a press event after reset release, per REQ-022.

Configuration
REQ-034 Macro KEY_EVTFIFO_EN SHALL select the event queue size.
REQ-035 With KEY_EVTFIFO_EN defined, the queue SHALL be a 4-entry FIFO with 2-bit read/write pointers that wrap modulo 4 and a 3-bit count 0..4; full = (count == 4).
REQ-036 Without KEY_EVTFIFO_EN, the queue SHALL be a single holding register; full = EvtValid.
REQ-037 All other behaviour, including drop and Overflow rules, SHALL be identical with or without KEY_EVTFIFO_EN.

Verification (T10MS = 10)
REQ-038 A bench SHALL cover: KEY[2] 1->0 held, EvtReady = 1 -> EvtValid pulses 1 cycle, 14 edges after the change, EvtCode = 3'b110; KeyState = 4'b1011.
REQ-039 A bench SHALL cover: KEY[1] low for 3 cycles then high (glitch) -> no event; KeyState = 4'b1111; FSM back in IDLE after 12 edges.
REQ-040 A bench SHALL cover: KEY = 4'b0000 at once after reset, EvtReady = 1 -> presses in order 3'b100, 3'b101, 3'b110, 3'b111, spaced 12 cycles apart.
REQ-041 A bench SHALL cover: EvtReady = 0, six distinct key edges -> with KEY_EVTFIFO_EN: 4 held, Overflow = 1 after the 5th, and the first 4 dequeue in order; without KEY_EVTFIFO_EN: 1 held, Overflow = 1 after the 2nd.
REQ-042 A bench SHALL cover: RESET = 0 for 1 cycle at C1 = 5 in DEBOUNCE of KEY[0] held low -> no event at the original time; press 3'b100 appears 14 edges after reset release.
REQ-043 A bench SHALL cover: full queue, EvtReady = 1 on the same cycle as CONFIRM enqueue -> Overflow stays 0 and the new event is last in order.
